priority_resolver: RTL
======================

# priority_resolver

Downstream stage of the PIC8259 interrupt request register. It takes the masked request vector from the IRR and resolves the highest-priority request using fully nested, optionally rotating priority. It runs the two-pulse INTA acknowledge sequence, maintains the In-Service Register (ISR), and emits the 8-bit interrupt vector. It also processes EOI commands from the control logic.

## Interface
Parameters:
- NUM_IR, 8, number of interrupt lines; fixed at 8 for this block.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IRR  in  8  masked request vector from the IRR stage.
- INTA  in  1  one-cycle strobe per INTA bus cycle, already synchronised.
- Vector_Base  in  5  ICW2 bits T7..T3.
- EOI_cmd  in  1  one-cycle EOI command strobe.
- EOI_specific  in  1  qualifies EOI_cmd: 1 = specific, 0 = non-specific.
- EOI_level  in  3  target level for a specific EOI.
- Rotate_on_EOI  in  1  if 1, the cleared level becomes lowest priority.
- AEOI  in  1  automatic EOI enable; present only with AUTO_EOI_EN.
- INT  out  1  interrupt request to the CPU.
- ISR  out  8  in-service register.
- Clear_IRR  out  8  one-hot, one-cycle pulse that clears the acknowledged edge latch in the IRR.
- Vector  out  8  {Vector_Base, level}.
- Vector_valid  out  1  one-cycle qualifier for Vector.

## Operation
- Lowest register (3 bits, reset 7): highest priority is (Lowest+1) mod 8.
- Winner: the set IRR bit ranked first by rotating priority. The ISR top bit is found the same way.
- A request is eligible only if it ranks strictly above the ISR top bit, or ISR == 0.
- FSM states: IDLE, REQ, ACK1.
  - IDLE -> REQ: an eligible winner exists. INT is set to 1.
  - REQ -> IDLE: the eligible winner disappears before INTA. INT is set to 0. This is not an error.
  - REQ -> ACK1 on INTA:
    - Latch the winner level.
    - Set its ISR bit.
    - Pulse Clear_IRR for that bit.
    - Set INT to 0.
  - INTA in IDLE (spurious): go to ACK1 with level 7, ISR unchanged, no Clear_IRR pulse.
  - ACK1 -> IDLE on the second INTA: Vector = {Vector_Base, level}, Vector_valid = 1 for one cycle.
- EOI_cmd handling:
  - Non-specific EOI clears the ISR top bit.
  - Specific EOI clears ISR[EOI_level].
  - If Rotate_on_EOI = 1, Lowest is set to the cleared level.
  - EOI with ISR == 0, or a specific EOI to a clear bit: no effect, Lowest unchanged.
- EOI coincident with an ISR set in ACK1 entry: the clear target is computed from the old ISR. If clear and set hit the same bit, set wins.
- Lowered IRR during ACK1 has no effect; the level is already latched.
- EOI in any state is processed.
- An ISR change can re-evaluate eligibility in IDLE only.

## Timing
- Reset values:
  - INT = 0, ISR = 0, Clear_IRR = 0, Vector = 0, Vector_valid = 0.
  - Lowest = 7, state = IDLE.
- Reset mid-sequence aborts it: no vector, no ISR bit.
- IRR to INT latency: 1 cycle (registered).
- First INTA in cycle n:
  - ISR bit and Clear_IRR pulse visible in cycle n+1.
  - INT is 0 in cycle n+1.
- Second INTA in cycle m: Vector and Vector_valid visible in cycle m+1. Vector holds its value afterwards.
- EOI effect is visible on ISR one cycle after EOI_cmd.
- INTA and EOI_cmd are single-cycle. A held level counts as repeated strobes.

## Configuration
- AUTO_EOI_EN defined:
  - The AEOI port exists.
  - With AEOI = 1, the ISR bit of the acknowledged level is cleared in the cycle after the second INTA. If Rotate_on_EOI = 1, rotation applies.
  - With AEOI = 0, behaviour is identical to the build without the macro.
- AUTO_EOI_EN undefined: the port is absent and the ISR clears only via EOI_cmd.

## Structure
- Shared package pic_pkg:
  - FSM state enum.
  - 3-bit level type.
  - Vector width constant.
- Sub-module rot_prio_enc: combinational rotating highest-priority finder.
  - Inputs: 8-bit vector and Lowest.
  - Outputs: found flag and 3-bit level.
  - Instantiated twice, once for IRR and once for ISR.

## Test plan
- Reset, IRR = 8'h24, Vector_Base = 5'b10101, two INTAs:
  - INT = 1 after 1 cycle.
  - After the first INTA: ISR = 8'h04, Clear_IRR = 8'h04.
  - After the second INTA: Vector = 8'hAA with a single Vector_valid pulse.
- Nesting:
  - ISR = 8'h04, IRR = 8'h10: INT stays 0.
  - IRR = 8'h01: INT = 1. After acknowledge, ISR = 8'h05.
- Non-specific EOI with ISR = 8'h05 and Rotate_on_EOI = 1:
  - ISR = 8'h04, Lowest = 0.
  - IRR = 8'h03 then resolves level 1.
- INTA with IRR = 0 (spurious): Vector = {base, 3'd7}, ISR unchanged, Clear_IRR = 0.
- rst asserted between the two INTAs: all outputs return to reset values, and a following INTA is treated as spurious.
- AUTO_EOI_EN with AEOI = 1, IRR = 8'h08 acknowledged: ISR = 8'h00 one cycle after Vector_valid.

Source files
------------

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the PIC8259 priority resolution slice.
//   - pr_state_t : acknowledge sequencer states (IDLE, REQ, ACK1)
//   - level_t    : 3-bit interrupt level
//   - VECTOR_W   : width of the emitted interrupt vector
//   - rank_of()  : position of a level in the rotating priority order,
//                  0 = highest priority, 7 = lowest
// ---------------------------------------------------------------------------
package pic_pkg;

    localparam int NUM_LEVELS = 8;
    localparam int VECTOR_W   = 8;

    typedef logic [2:0] level_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK1 = 2'd2
    } pr_state_t;

    // The level just above 'lowest' ranks 0, so the distance is simply
    // (lvl - lowest - 1) taken modulo 8 by the 3-bit arithmetic.
    function automatic level_t rank_of(input level_t lvl, input level_t lowest);
        return lvl - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/rot_prio_enc.sv
// ---------------------------------------------------------------------------
// rot_prio_enc
// Combinational rotating highest-priority finder.
// Ports:
//   req    in  8  request vector to search
//   lowest in  3  level currently holding lowest priority
//   found  out 1  at least one bit of req is set
//   level  out 3  level of the highest-priority set bit
// ---------------------------------------------------------------------------
module rot_prio_enc
    import pic_pkg::*;
(
    input  logic [NUM_LEVELS-1:0] req,
    input  level_t                lowest,
    output logic                  found,
    output level_t                level
);

    level_t cand;

    // Walk from the lowest-priority position (lowest itself) towards the
    // highest (lowest+1); the last hit encountered is the winner.
    always_comb begin
        found = 1'b0;
        level = '0;
        cand  = '0;
        for (int k = NUM_LEVELS; k >= 1; k--) begin
            cand = lowest + level_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                level = cand;
            end
        end
    end

endmodule

// File: rtl/priority_resolver.sv
// ---------------------------------------------------------------------------
// priority_resolver
// Resolves the highest-priority masked request using fully nested, optionally
// rotating priority, runs the two-pulse INTA acknowledge sequence, maintains
// the In-Service Register and emits the interrupt vector. Also executes EOI
// commands.
//
// Optional feature macro: AUTO_EOI_EN (adds the AEOI port and automatic EOI).
//
// Ports:
//   clk           in   1  system clock
//   rst           in   1  synchronous active-high reset
//   IRR           in   8  masked request vector
//   INTA          in   1  one-cycle strobe per INTA bus cycle
//   Vector_Base   in   5  ICW2 T7..T3
//   EOI_cmd       in   1  one-cycle EOI command strobe
//   EOI_specific  in   1  1 = specific EOI, 0 = non-specific
//   EOI_level     in   3  target level of a specific EOI
//   Rotate_on_EOI in   1  cleared level becomes lowest priority
//   AEOI          in   1  automatic EOI enable (AUTO_EOI_EN only)
//   INT           out  1  interrupt request to the CPU
//   ISR           out  8  in-service register
//   Clear_IRR     out  8  one-hot pulse clearing the acknowledged IRR latch
//   Vector        out  8  {Vector_Base, level}
//   Vector_valid  out  1  one-cycle qualifier for Vector
// ---------------------------------------------------------------------------
module priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IR = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IR-1:0]   IRR,
    input  logic                INTA,
    input  logic [4:0]          Vector_Base,
    input  logic                EOI_cmd,
    input  logic                EOI_specific,
    input  logic [2:0]          EOI_level,
    input  logic                Rotate_on_EOI,
`ifdef AUTO_EOI_EN
    input  logic                AEOI,
`endif
    output logic                INT,
    output logic [NUM_IR-1:0]   ISR,
    output logic [NUM_IR-1:0]   Clear_IRR,
    output logic [VECTOR_W-1:0] Vector,
    output logic                Vector_valid
);

    pr_state_t   state;
    level_t      lowest;
    level_t      ack_level;

    logic        irr_found;
    level_t      irr_level;
    logic        isr_found;
    level_t      isr_level;

    logic        eligible;
    logic        eoi_hit;
    level_t      eoi_target;
    logic        aeoi_hit;
    logic [NUM_IR-1:0] set_mask;
    logic [NUM_IR-1:0] clr_mask;
    logic [NUM_IR-1:0] isr_next;

    rot_prio_enc u_irr_enc (
        .req    (IRR),
        .lowest (lowest),
        .found  (irr_found),
        .level  (irr_level)
    );

    rot_prio_enc u_isr_enc (
        .req    (ISR),
        .lowest (lowest),
        .found  (isr_found),
        .level  (isr_level)
    );

    // A request may interrupt only if it strictly outranks whatever is
    // currently in service; an equal rank (same level) is not enough.
    always_comb begin
        eligible = irr_found &&
                   (!isr_found || (rank_of(irr_level, lowest) < rank_of(isr_level, lowest)));
    end

    // EOI target selection works on the ISR as it stands before any
    // acknowledge that lands in the same cycle.
    always_comb begin
        eoi_hit    = 1'b0;
        eoi_target = isr_level;
        if (EOI_cmd) begin
            if (EOI_specific) begin
                eoi_target = EOI_level;
                eoi_hit    = ISR[EOI_level];
            end else begin
                eoi_target = isr_level;
                eoi_hit    = isr_found;
            end
        end
    end

`ifdef AUTO_EOI_EN
    logic ack_real;

    // Automatic EOI fires on the second INTA of a genuine acknowledge only;
    // a spurious level 7 never owned an ISR bit.
    always_comb begin
        aeoi_hit = AEOI && ack_real && (state == ST_ACK1) && INTA && ISR[ack_level];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_real <= 1'b0;
        end else if (INTA && (state != ST_ACK1)) begin
            ack_real <= (state == ST_REQ) && eligible;
        end
    end
`else
    always_comb begin
        aeoi_hit = 1'b0;
    end
`endif

    // Set is applied after clear so that a simultaneous set and clear of the
    // same bit leaves the bit set.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if ((state == ST_REQ) && INTA && eligible) begin
            set_mask = NUM_IR'(1) << irr_level;
        end
        if (eoi_hit) begin
            clr_mask = clr_mask | (NUM_IR'(1) << eoi_target);
        end
        if (aeoi_hit) begin
            clr_mask = clr_mask | (NUM_IR'(1) << ack_level);
        end
        isr_next = (ISR & ~clr_mask) | set_mask;
    end

    // ISR and rotation state; EOI is honoured in every sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ISR       <= '0;
            Clear_IRR <= '0;
            lowest    <= 3'd7;
        end else begin
            ISR       <= isr_next;
            Clear_IRR <= set_mask;
            if (Rotate_on_EOI) begin
                if (eoi_hit) begin
                    lowest <= eoi_target;
                end else if (aeoi_hit) begin
                    lowest <= ack_level;
                end
            end
        end
    end

    // Acknowledge sequencer. An INTA that arrives without an eligible
    // request behind it is answered as spurious with level 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            INT          <= 1'b0;
            ack_level    <= 3'd7;
            Vector       <= '0;
            Vector_valid <= 1'b0;
        end else begin
            Vector_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (INTA) begin
                        state     <= ST_ACK1;
                        ack_level <= 3'd7;
                    end else if (eligible) begin
                        state <= ST_REQ;
                        INT   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (INTA) begin
                        state     <= ST_ACK1;
                        INT       <= 1'b0;
                        ack_level <= eligible ? irr_level : 3'd7;
                    end else if (!eligible) begin
                        state <= ST_IDLE;
                        INT   <= 1'b0;
                    end
                end
                ST_ACK1: begin
                    if (INTA) begin
                        state        <= ST_IDLE;
                        Vector       <= {Vector_Base, ack_level};
                        Vector_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    INT   <= 1'b0;
                end
            endcase
        end
    end

endmodule
